main_mem_block_responder: RTL

- Main-memory end of the cache refill/write-through interface: services 128-bit block reads on a cache read miss and 32-bit word writes from the write-through path.
- Sits between the cache data controller and the backing word-addressed RAM.
- Models fixed multi-cycle memory latency with a level-request / one-cycle-ready handshake.

---
 rtl/main_mem_block_responder.sv | 111 +++++++++++
 1 files changed

// File: rtl/main_mem_block_responder.sv
// main_mem_block_responder: fixed-latency main memory servicing 128-bit block reads and 32-bit word writes.
// Optional MEM_ACCESS_STATS_EN adds read_count/write_count completion counters.
module main_mem_block_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           write_data,
   output logic [127:0]          block_from_mem,
   output logic                  ready,
   output logic                  busy
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [15:0]           read_count,
   output logic [15:0]           write_count
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
   logic [31:0] ram [DEPTH];
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [127:0] block_q, block_d;
   logic ready_q, ready_d;
   logic busy_q, busy_d;
   logic [ADDR_WIDTH-3:0] blk;
   logic ram_we;
   assign blk = addr_q[ADDR_WIDTH-1:2];
   assign ram_we = (state_q == RESP) && wr_q;
   assign block_from_mem = block_q;
   assign ready = ready_q;
   assign busy = busy_q;
`ifdef MEM_ACCESS_STATS_EN
   logic [15:0] read_count_q, read_count_d;
   logic [15:0] write_count_q, write_count_d;
   assign read_count = read_count_q;
   assign write_count = write_count_q;
   // Count each operation once, on the edge that completes it (leaving RESP).
   always_comb begin
      read_count_d = read_count_q + 16'((state_q == RESP) && !wr_q);
      write_count_d = write_count_q + 16'(ram_we);
   end
`endif
   // Next-state logic: capture request in IDLE, count down latency, fetch the whole block on entry to RESP.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      wr_d = wr_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      block_d = block_q;
      case (state_q)
         IDLE: if (mem_read || mem_write) begin
            state_d = WAIT;
            cnt_d = LAT_M1;
            wr_d = mem_write;
            addr_d = addr;
            wdata_d = write_data;
         end
         WAIT: if (cnt_q == 4'd0) state_d = RESP; else cnt_d = cnt_q - 4'd1;
         RESP: state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (state_q == WAIT && state_d == RESP && !wr_q)
         block_d = {ram[{blk, 2'b11}], ram[{blk, 2'b10}], ram[{blk, 2'b01}], ram[{blk, 2'b00}]};
      ready_d = state_d == RESP;
      busy_d = state_d != IDLE;
   end
   // Control and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         wr_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         block_q <= '0;
         ready_q <= 1'b0;
         busy_q <= 1'b0;
`ifdef MEM_ACCESS_STATS_EN
         read_count_q <= '0;
         write_count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         wr_q <= wr_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         block_q <= block_d;
         ready_q <= ready_d;
         busy_q <= busy_d;
`ifdef MEM_ACCESS_STATS_EN
         read_count_q <= read_count_d;
         write_count_q <= write_count_d;
`endif
      end
   end
   // Word write commits on the edge leaving RESP unless reset is asserted on that edge.
   always_ff @(posedge clk) begin
      if (rst_n && ram_we) ram[addr_q] <= wdata_q;
   end
endmodule
